// File: rtl/if_fetch_if.sv
// Bundles the fetch stage's instruction-cache handshake, redirect/stall control
// and IR load port; master is the fetch stage, slave is its environment.
interface if_fetch_if;
  logic [15:0] icache_addr;
  logic        icache_read;
  logic        icache_resp;
  logic [15:0] icache_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        ir_load;
  logic [15:0] ir_data;
  logic [15:0] ir_pc;
  logic [1:0]  buf_count;

  modport master (
    output icache_addr, icache_read, ir_load, ir_data, ir_pc, buf_count,
    input  icache_resp, icache_rdata, redirect, redirect_pc, stall
  );

  modport slave (
    input  icache_addr, icache_read, ir_load, ir_data, ir_pc, buf_count,
    output icache_resp, icache_rdata, redirect, redirect_pc, stall
  );
endinterface

// File: rtl/if_fetch.sv
// LC-3b instruction fetch: single-outstanding icache reads feeding a 2-entry
// prefetch FIFO that presents one instruction per cycle to the IR.
module if_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic          clk,
  input  logic          reset_n,
  if_fetch_if.master    bus
);

  typedef enum logic [1:0] {IDLE, FETCH, FULL, FLUSH} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [15:0] r_target, w_target_nxt;
  logic [15:0] r_instr [2];
  logic [15:0] r_pcinc [2];
  logic        r_rd_ptr, r_wr_ptr;
  logic [1:0]  r_count;
  logic        w_push, w_pop;
  logic [15:0] w_redirect_pc;

  assign w_redirect_pc = bus.redirect_pc & 16'hFFFE;

  // Redirect outranks both FIFO ports; a response is only kept in FETCH.
  assign w_pop  = (r_count != 2'd0) && !bus.stall && !bus.redirect;
  assign w_push = bus.icache_resp && (r_state == FETCH) && !bus.redirect;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_target_nxt   = r_target;
    case (r_state)
      IDLE: begin
        w_state_nxt = FETCH;
        if (bus.redirect) w_fetch_pc_nxt = w_redirect_pc;
      end
      FETCH: begin
        if (bus.redirect) begin
          if (bus.icache_resp) begin
            w_fetch_pc_nxt = w_redirect_pc;
          end else begin
            w_target_nxt = w_redirect_pc;
            w_state_nxt  = FLUSH;
          end
        end else if (w_push) begin
          w_fetch_pc_nxt = r_fetch_pc + 16'd2;
          if (r_count == 2'd1 && !w_pop) w_state_nxt = FULL;
        end
      end
      FULL: begin
        if (bus.redirect) begin
          w_fetch_pc_nxt = w_redirect_pc;
          w_state_nxt    = FETCH;
        end else if (w_pop) begin
          w_state_nxt = FETCH;
        end
      end
      FLUSH: begin
        // The abandoned request keeps its address on the bus until it completes.
        if (bus.icache_resp) begin
          w_fetch_pc_nxt = bus.redirect ? w_redirect_pc : r_target;
          w_state_nxt    = FETCH;
        end else if (bus.redirect) begin
          w_target_nxt = w_redirect_pc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_target   <= 16'h0000;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_target   <= w_target_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (bus.redirect) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: FIFO payload is not reset; the outputs are gated by r_count, so
  // stale entries are never visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wr_ptr] <= bus.icache_rdata;
      r_pcinc[r_wr_ptr] <= r_fetch_pc + 16'd2;
    end
  end

  assign bus.icache_read = (r_state == FETCH) || (r_state == FLUSH);
  assign bus.icache_addr = r_fetch_pc;
  assign bus.ir_load     = w_pop;
  assign bus.ir_data     = (r_count != 2'd0) ? r_instr[r_rd_ptr] : 16'h0000;
  assign bus.ir_pc       = (r_count != 2'd0) ? r_pcinc[r_rd_ptr] : 16'h0000;
  assign bus.buf_count   = r_count;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus random traffic,
// compared each cycle against a queue-based model of the fetch stage.
module tb_if_fetch;

  localparam logic [15:0] RESET_PC = 16'h3000;

  logic clk = 1'b0;
  logic reset_n;

  if_fetch_if bus ();

  if_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pcinc;
  } ent_t;

  // Model: words waiting for the IR, next fetch address, and whether an
  // abandoned request is still in flight (with the address to resume at).
  ent_t        m_q[$];
  logic [15:0] m_pc;
  logic [15:0] m_target;
  bit          m_idle;
  bit          m_flush;

  int          n_cmp;
  int          n_err;
  int          cyc;
  int          c_wait;
  int          lat;
  logic [15:0] salt;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc     = RESET_PC;
    m_target = 16'h0000;
    m_idle   = 1'b1;
    m_flush  = 1'b0;
    c_wait   = 0;
  endtask

  task automatic check_reset();
    check("rst_icache_read", 16'(bus.icache_read), 16'h0000);
    check("rst_icache_addr", bus.icache_addr, RESET_PC);
    check("rst_ir_load", 16'(bus.ir_load), 16'h0000);
    check("rst_ir_data", bus.ir_data, 16'h0000);
    check("rst_ir_pc", bus.ir_pc, 16'h0000);
    check("rst_buf_count", 16'(bus.buf_count), 16'h0000);
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs against
  // the model, then advance the model to what the next rising edge commits.
  task automatic step(input bit rd, input logic [15:0] rpc, input bit st, input bit force_resp);
    bit          resp;
    bit          exp_read;
    bit          exp_load;
    logic [15:0] rdata;
    logic [15:0] rpc_al;
    ent_t        head;
    ent_t        ent;
    @(negedge clk);
    cyc++;
    exp_read = !m_idle && (m_q.size() < 2);
    resp = 1'b0;
    if (bus.icache_read) begin
      if (c_wait >= lat) begin
        resp   = 1'b1;
        c_wait = 0;
      end else begin
        c_wait++;
      end
    end else begin
      c_wait = 0;
    end
    resp  = resp | force_resp;
    rdata = (bus.icache_addr >> 1) ^ salt;
    bus.icache_resp  = resp;
    bus.icache_rdata = rdata;
    bus.redirect     = rd;
    bus.redirect_pc  = rpc;
    bus.stall        = st;
    #1;
    exp_load = (m_q.size() != 0) && !st && !rd;
    head     = (m_q.size() != 0) ? m_q[0] : '0;
    check("icache_read", 16'(bus.icache_read), 16'(exp_read));
    check("icache_addr", bus.icache_addr, m_pc);
    check("ir_load", 16'(bus.ir_load), 16'(exp_load));
    check("ir_data", bus.ir_data, head.instr);
    check("ir_pc", bus.ir_pc, head.pcinc);
    check("buf_count", 16'(bus.buf_count), 16'(m_q.size()));

    rpc_al = rpc & 16'hFFFE;
    if (m_idle) begin
      m_idle = 1'b0;
      if (rd) m_pc = rpc_al;
    end else if (rd) begin
      m_q.delete();
      if (exp_read && !resp && !m_flush) begin
        m_flush  = 1'b1;
        m_target = rpc_al;
      end else if (m_flush && !resp) begin
        m_target = rpc_al;
      end else begin
        m_pc    = rpc_al;
        m_flush = 1'b0;
      end
    end else begin
      if (exp_load) void'(m_q.pop_front());
      if (m_flush && resp) begin
        m_pc    = m_target;
        m_flush = 1'b0;
      end else if (exp_read && resp) begin
        ent = {rdata, m_pc + 16'd2};
        m_q.push_back(ent);
        m_pc = m_pc + 16'd2;
      end
    end
  endtask

  // Advance until the coming cycle is the second cycle of an open request.
  task automatic wait_req_age1();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 16'h0000, 1'b0, 1'b0);
      if (c_wait == 1) begin
        found = 1'b1;
        break;
      end
    end
    check("wait_req_age1_timeout", 16'(found), 16'h0001);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    lat   = 0;
    salt  = 16'h0000;
    reset_n          = 1'b0;
    bus.icache_resp  = 1'b0;
    bus.icache_rdata = 16'h0000;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = 16'h0000;
    bus.stall        = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_reset();
    @(posedge clk);
    #2 reset_n = 1'b1;

    // Zero-wait cache streaming from RESET_PC.
    repeat (12) step(1'b0, 16'h0000, 1'b0, 1'b0);

    // Stall fills the buffer and parks the fetch; release drains without loss.
    repeat (6) step(1'b0, 16'h0000, 1'b1, 1'b0);
    repeat (6) step(1'b0, 16'h0000, 1'b0, 1'b0);

    // Slow cache, redirect one cycle into a request: old response dropped.
    lat = 3;
    wait_req_age1();
    step(1'b1, 16'h4000, 1'b0, 1'b0);
    repeat (16) step(1'b0, 16'h0000, 1'b0, 1'b0);

    // Redirect coincident with a response.
    lat = 0;
    repeat (3) step(1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 16'h5000, 1'b0, 1'b0);
    repeat (4) step(1'b0, 16'h0000, 1'b0, 1'b0);

    // Redirect while full and stalled; odd target has bit 0 dropped.
    repeat (4) step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b1, 16'h6001, 1'b1, 1'b0);
    repeat (4) step(1'b0, 16'h0000, 1'b0, 1'b0);

    // Address wrap at the top of memory.
    step(1'b1, 16'hFFFE, 1'b0, 1'b0);
    repeat (6) step(1'b0, 16'h0000, 1'b0, 1'b0);

    // Asynchronous reset with the buffer full; responses during and just
    // after reset are ignored and fetch restarts at RESET_PC.
    repeat (4) step(1'b0, 16'h0000, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_reset();
    bus.stall       = 1'b0;
    bus.icache_resp = 1'b1;
    repeat (2) @(posedge clk);
    #2 check_reset();
    bus.icache_resp = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    repeat (8) step(1'b0, 16'h0000, 1'b0, 1'b0);

    // Random traffic: latency, data, stalls and redirects.
    for (int seg = 0; seg < 6; seg++) begin
      lat  = int'($urandom_range(0, 3));
      salt = 16'($urandom);
      for (int k = 0; k < 60; k++) begin
        step($urandom_range(0, 15) == 0, 16'($urandom), $urandom_range(0, 2) == 0, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
